// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, LSB first) feeding a first-word-fall-through byte FIFO,
// with sticky overrun / framing-error flags and a not-empty interrupt level.
module uart_rx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned DEPTH        = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rx,
    input  logic                     rd_en,
    input  logic                     clr_err,
    output logic [7:0]               rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun,
    output logic                     frame_err,
    output logic                     interrupt
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT) + 1;
    localparam int unsigned PtrW = $clog2(DEPTH);

    localparam logic [CntW-1:0] HalfBit   = CntW'(CLKS_PER_BIT / 2);
    localparam logic [CntW-1:0] FullBit   = CntW'(CLKS_PER_BIT);
    localparam logic [PtrW:0]   CountFull = (PtrW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronizer and edge history
    // ------------------------------------------------------------------
    logic       rx_meta;
    logic       rx_sync;
    logic       rx_prev;
    // Marks when rx_sync holds a real line sample rather than its reset value.
    logic [1:0] sync_fill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            sync_fill <= 2'b00;
        end else begin
            rx_meta   <= rx;
            rx_sync   <= rx_meta;
            rx_prev   <= rx_sync;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            armed_q, armed_d;
    logic            tick;
    logic            push;
    logic            ferr_set;

    assign tick = (clk_cnt_q == CntW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            armed_q   <= armed_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        armed_d   = armed_q;
        push      = 1'b0;
        ferr_set  = 1'b0;

        if (sync_fill[1] && rx_sync) begin
            armed_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (armed_q && rx_prev && !rx_sync) begin
                    state_d   = StStart;
                    clk_cnt_d = HalfBit;
                end
            end
            StStart: begin
                if (tick) begin
                    if (!rx_sync) begin
                        state_d   = StData;
                        clk_cnt_d = FullBit;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q - CntW'(1);
                end
            end
            StData: begin
                if (tick) begin
                    shift_d   = {rx_sync, shift_q[7:1]};
                    clk_cnt_d = FullBit;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q - CntW'(1);
                end
            end
            StStop: begin
                if (tick) begin
                    state_d = StIdle;
                    if (rx_sync) begin
                        push = 1'b1;
                    end else begin
                        // Disarm so a held-low line (break) reports only one error.
                        ferr_set = 1'b1;
                        armed_d  = 1'b0;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q - CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]      mem [DEPTH];
    logic [PtrW-1:0] wptr_q;
    logic [PtrW-1:0] rptr_q;
    logic [PtrW:0]   count_q;
    logic            do_pop;
    logic            do_push;
    logic            overrun_set;
    logic            overrun_q;
    logic            frame_err_q;

    assign empty       = (count_q == '0);
    assign full        = (count_q == CountFull);
    assign do_pop      = rd_en && !empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign do_push     = push && (!full || do_pop);
    assign overrun_set = push && full && !do_pop;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_q] <= shift_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + PtrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PtrW + 1)'(1);
                2'b01:   count_q <= count_q - (PtrW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Setting a flag wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (overrun_set) begin
                overrun_q <= 1'b1;
            end else if (clr_err) begin
                overrun_q <= 1'b0;
            end
            if (ferr_set) begin
                frame_err_q <= 1'b1;
            end else if (clr_err) begin
                frame_err_q <= 1'b0;
            end
        end
    end

    assign rd_data   = mem[rptr_q];
    assign count     = count_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign interrupt = !empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed UART frames, a queue-based FIFO model that
// schedules each frame's push from its start-bit time, plus literal spot checks.
module tb_uart_rx_fifo;

    localparam int N = 8;
    localparam int D = 4;
    // Edges from the first start-bit capture to the stop-bit sample.
    localparam int PushLat = 2 + N / 2 + 9 * N;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [2:0] count;
    logic       overrun;
    logic       frame_err;
    logic       interrupt;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLKS_PER_BIT (N),
        .DEPTH        (D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rd_en     (rd_en),
        .clr_err   (clr_err),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overrun   (overrun),
        .frame_err (frame_err),
        .interrupt (interrupt)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
    endtask

    // ---------------- model ----------------
    logic [7:0] q[$];
    bit         m_ovr = 0;
    bit         m_ferr = 0;
    int         cyc = 0;
    int         pend_edge = -1;
    logic [7:0] pend_byte = 8'h00;
    bit         pend_ferr = 0;
    bit         m_pop;
    bit         m_hit;
    logic [7:0] exp_status;
    logic [7:0] act_status;

    initial forever begin
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            q.delete();
            m_ovr  = 0;
            m_ferr = 0;
        end else begin
            m_pop = rd_en && (q.size() != 0);
            m_hit = (cyc == pend_edge);
            if (m_pop) void'(q.pop_front());
            if (clr_err) begin
                m_ovr  = 0;
                m_ferr = 0;
            end
            if (m_hit && pend_ferr) m_ferr = 1;
            else if (m_hit) begin
                if (q.size() < D) q.push_back(pend_byte);
                else m_ovr = 1;
            end
        end
        #1;
        exp_status = {q.size() == 0, q.size() == D, 3'(q.size()), m_ovr, m_ferr, q.size() != 0};
        act_status = {empty, full, count, overrun, frame_err, interrupt};
        check("status{empty,full,count,ovr,ferr,irq}", 16'(act_status), 16'(exp_status));
        if (q.size() != 0) check("rd_data", 16'(rd_data), 16'(q[0]));
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic v, input int n);
        repeat (n) begin
            @(negedge clk);
            rx = v;
        end
    endtask

    // act: 0 none, 1 rd_en on the push edge, 2 clr_err on the push edge
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int act);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < N; j++) begin
                @(negedge clk);
                if (i == 0 && j == 0) begin
                    pend_edge = cyc + 1 + PushLat;
                    pend_byte = b;
                    pend_ferr = !stop_bit;
                end
                rx      = bits[i];
                rd_en   = (act == 1) && (cyc + 1 == pend_edge);
                clr_err = (act == 2) && (cyc + 1 == pend_edge);
            end
        end
    endtask

    task automatic read_one();
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [7:0] e;
        idle(3);
        check("reset_empty", 16'(empty), 16'h1);
        check("reset_count", 16'(count), 16'h0);
        rst_n = 1'b1;
        idle(10);

        // Single frame then pop; extra pop while empty must be ignored.
        send_frame(8'hA5, 1'b1, 0);
        check("a5_data", 16'(rd_data), 16'h00A5);
        check("a5_count", 16'(count), 16'h1);
        check("a5_irq", 16'(interrupt), 16'h1);
        read_one();
        check("a5_pop_empty", 16'(empty), 16'h1);
        check("a5_pop_count", 16'(count), 16'h0);
        read_one();
        check("pop_when_empty_count", 16'(count), 16'h0);

        // Short low glitch on idle line.
        drive(1'b0, 3);
        drive(1'b1, 30);
        check("glitch_empty", 16'(empty), 16'h1);
        check("glitch_ferr", 16'(frame_err), 16'h0);

        // Overflow; clr_err on the overrun edge loses to the set.
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, (i == 5) ? 2 : 0);
        check("ovr_full", 16'(full), 16'h1);
        check("ovr_count", 16'(count), 16'h4);
        check("ovr_flag", 16'(overrun), 16'h1);
        for (int i = 1; i <= 4; i++) begin
            e = 8'(i);
            check("ovr_order", 16'(rd_data), 16'(e));
            read_one();
        end
        check("ovr_drained", 16'(empty), 16'h1);
        pulse_clr();
        check("ovr_cleared", 16'(overrun), 16'h0);

        // Framing error followed by a long break.
        send_frame(8'h77, 1'b0, 0);
        drive(1'b0, 20);
        check("ferr_set", 16'(frame_err), 16'h1);
        check("ferr_no_push", 16'(empty), 16'h1);
        pulse_clr();
        drive(1'b0, 20);
        check("ferr_once", 16'(frame_err), 16'h0);
        drive(1'b1, 2 * N);
        send_frame(8'h3C, 1'b1, 0);
        check("after_break_data", 16'(rd_data), 16'h003C);
        read_one();

        // Full FIFO with a pop on the push edge; pointers wrap here.
        for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1, 0);
        check("wrap_full", 16'(full), 16'h1);
        send_frame(8'h14, 1'b1, 1);
        check("wrap_count", 16'(count), 16'h4);
        check("wrap_no_ovr", 16'(overrun), 16'h0);
        check("wrap_head", 16'(rd_data), 16'h0011);
        read_one();
        check("wrap_next", 16'(rd_data), 16'h0012);
        read_one();

        // Reset during data bit 4 with the line low at release.
        drive(1'b0, N);
        drive(1'b1, N);
        drive(1'b0, N);
        drive(1'b1, 2 * N);
        drive(1'b0, 3);
        rst_n = 1'b0;
        idle(4);
        check("mid_reset_count", 16'(count), 16'h0);
        check("mid_reset_empty", 16'(empty), 16'h1);
        rst_n = 1'b1;
        drive(1'b0, 30);
        drive(1'b1, 20);
        check("post_reset_empty", 16'(empty), 16'h1);
        check("post_reset_ferr", 16'(frame_err), 16'h0);
        send_frame(8'h5A, 1'b1, 0);
        check("post_reset_data", 16'(rd_data), 16'h005A);
        check("post_reset_count", 16'(count), 16'h1);

        idle(5);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, clk cycles per UART bit (1 MHz mclk, 9600 baud); legal range 4..65535.
REQ-002 SHALL have parameter DEPTH, default 8, FIFO entries; power of two, 2..64.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx  input  1  asynchronous UART line, idle high.
REQ-006 SHALL have port rd_en  input  1  pop head entry at the next rising clk edge.
REQ-007 SHALL have port clr_err  input  1  one-cycle pulse that clears the sticky error flags.
REQ-008 SHALL have port rd_data  output  8  head entry; valid while empty=0.
REQ-009 SHALL have port empty  output  1  FIFO holds no entries.
REQ-010 SHALL have port full  output  1  FIFO holds DEPTH entries.
REQ-011 SHALL have port count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-012 SHALL have port overrun  output  1  sticky flag: a received byte was dropped because the FIFO was full.
REQ-013 SHALL have port frame_err  output  1  sticky flag: the stop bit was sampled low.
REQ-014 SHALL have port interrupt  output  1  level signal equal to ~empty, for the com_block interrupt line.

Function
REQ-015 SHALL pass rx through a 2-flop synchronizer before any use; synchronizer flops reset to 1.
REQ-016 SHALL clear an armed flag on reset and set it after the synchronized rx is observed high; start detection is allowed only while armed.
REQ-017 SHALL implement receiver states IDLE, START, DATA, STOP with a bit counter and a clock counter of width $clog2(CLKS_PER_BIT)+1.
REQ-018 SHALL transition IDLE->START on a synchronized 1->0 transition while armed, then load the clock counter with CLKS_PER_BIT/2 (integer division).
REQ-019 SHALL re-sample rx in START when the counter expires: low -> DATA; high -> glitch, return to IDLE, nothing stored and no flag set.
REQ-020 SHALL sample 8 data bits in DATA, LSB first, each CLKS_PER_BIT cycles after the previous sample.
REQ-021 SHALL sample the stop bit in STOP CLKS_PER_BIT cycles after data bit 7.
REQ-022 SHALL, on a high stop-bit sample, push the byte on that same edge: empty=0 and the byte visible on rd_data one cycle later when the FIFO was empty.
REQ-023 SHALL, on a low stop-bit sample, discard the byte, set frame_err, clear armed, and return to IDLE, so a break condition produces exactly one error.
REQ-024 SHALL return to IDLE from STOP on the stop-bit sample cycle, so back-to-back frames with a single stop bit are received.
REQ-025 SHALL present the head entry combinationally from storage on rd_data (first-word fall-through).
REQ-026 SHALL ignore rd_en while empty=1: no pointer or count change.
REQ-027 SHALL, when full and no same-cycle pop, drop a push, set overrun, and leave FIFO contents unchanged.
REQ-028 SHALL, on a push and a pop in the same cycle, perform both with count unchanged; this includes the full case, which is then not an overrun.
REQ-029 SHALL use pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-030 SHALL give flag set priority over clr_err when both occur in the same cycle.

Reset
REQ-031 SHALL, while rst_n=0, hold the receiver in IDLE with armed=0, pointers=0, count=0, empty=1, full=0, overrun=0, frame_err=0, interrupt=0; rd_data is don't-care.
REQ-032 SHALL, on reset assertion mid-frame, abandon the partial byte; a frame already in progress when reset is released produces no stored byte unless rx is seen high before its falling edge.

Verification (CLKS_PER_BIT=8, DEPTH=4)
REQ-033 Bench SHALL send frame 0xA5 -> empty falls, rd_data=0xA5, count=1, interrupt=1; one rd_en -> empty=1, count=0.
REQ-034 Bench SHALL apply a 3-cycle low glitch on idle rx -> no push, flags unchanged.
REQ-035 Bench SHALL send 5 frames 0x01..0x05 with no reads -> full=1, count=4, overrun=1, reads return 0x01..0x04; clr_err -> overrun=0.
REQ-036 Bench SHALL send a frame with stop bit 0, then hold rx low for 40 cycles -> frame_err=1 once, no push; after rx high, frame 0x3C is received correctly.
REQ-037 Bench SHALL, with the FIFO full, assert rd_en on the push cycle -> count stays 4, overrun=0, order preserved across the pointer wrap.
REQ-038 Bench SHALL pulse rst_n low during data bit 4 with rx held low at release -> all outputs at reset values, no byte stored; the next clean frame 0x5A is received.
